// File: rtl/yarp_wb_pkg.sv
// Shared types and constants for the YARP register-file write-back path.
package yarp_wb_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/yarp_rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting at ptr, grants the
// first set bit (one-hot) and returns the pointer just past the winner.
module yarp_rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] next_ptr
);

  localparam int unsigned PTR_W = $clog2(N);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt      = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PTR_W'((32'(ptr) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        next_ptr = PTR_W'((32'(idx) + 1) % N);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/yarp_wb_arbiter.sv
// Write-back port arbiter: one-entry buffer per source, round-robin drain onto
// the single register-file write port. Optional bypass ports: YARP_WB_FWD_EN.
module yarp_wb_arbiter
  import yarp_wb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned XLEN    = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd_addr_i,
  input  logic [NUM_REQ*XLEN-1:0]       req_data_i,
  output logic                          rf_wr_en_o,
  output logic [REG_ADDR_W-1:0]         rf_rd_addr_o,
  output logic [XLEN-1:0]               rf_wr_data_o,
`ifdef YARP_WB_FWD_EN
  input  logic [REG_ADDR_W-1:0]         rs1_addr_i,
  input  logic [REG_ADDR_W-1:0]         rs2_addr_i,
  output logic                          rs1_fwd_vld_o,
  output logic                          rs2_fwd_vld_o,
  output logic [XLEN-1:0]               rs1_fwd_data_o,
  output logic [XLEN-1:0]               rs2_fwd_data_o,
`endif
  output logic [NUM_REQ-1:0]            grant_o
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  wb_req_t              buf_q [NUM_REQ];
  logic [NUM_REQ-1:0]   buf_vld;
  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     next_ptr;
  logic [NUM_REQ-1:0]   accept;
  logic [NUM_REQ-1:0]   load;

  yarp_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req      (buf_vld),
    .ptr      (ptr),
    .gnt      (grant_o),
    .next_ptr (next_ptr)
  );

  // A draining buffer can be refilled on the same edge.
  assign req_ready_o = ~buf_vld | grant_o;
  assign accept      = req_valid_i & req_ready_o;

  // Writes to x0 complete the handshake but never occupy the buffer.
  always_comb begin
    load = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      load[i] = accept[i] && (req_rd_addr_i[i*REG_ADDR_W +: REG_ADDR_W] != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_vld <= '0;
      ptr     <= '0;
    end else begin
      ptr <= next_ptr;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (load[i]) begin
          buf_vld[i]    <= 1'b1;
          buf_q[i].rd   <= req_rd_addr_i[i*REG_ADDR_W +: REG_ADDR_W];
          buf_q[i].data <= req_data_i[i*XLEN +: XLEN];
        end else if (grant_o[i]) begin
          buf_vld[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rf_wr_en_o   = |grant_o;
    rf_rd_addr_o = '0;
    rf_wr_data_o = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_o[i]) begin
        rf_rd_addr_o = buf_q[i].rd;
        rf_wr_data_o = buf_q[i].data;
      end
    end
  end

`ifdef YARP_WB_FWD_EN
  assign rs1_fwd_vld_o  = rf_wr_en_o && (rs1_addr_i == rf_rd_addr_o);
  assign rs2_fwd_vld_o  = rf_wr_en_o && (rs2_addr_i == rf_rd_addr_o);
  assign rs1_fwd_data_o = rs1_fwd_vld_o ? rf_wr_data_o : '0;
  assign rs2_fwd_data_o = rs2_fwd_vld_o ? rf_wr_data_o : '0;
`endif

endmodule

// File: tb/tb_yarp_wb_arbiter.sv
// Self-checking bench for yarp_wb_arbiter (NUM_REQ=2): directed vector table,
// hand-written streaming/fairness sequences and a randomized model comparison.
module tb_yarp_wb_arbiter;

  localparam int N = 2;

  logic          clk;
  logic          reset;
  logic [1:0]    req_valid_i;
  logic [1:0]    req_ready_o;
  logic [9:0]    req_rd_addr_i;
  logic [63:0]   req_data_i;
  logic          rf_wr_en_o;
  logic [4:0]    rf_rd_addr_o;
  logic [31:0]   rf_wr_data_o;
  logic [1:0]    grant_o;
`ifdef YARP_WB_FWD_EN
  logic [4:0]    rs1_addr_i, rs2_addr_i;
  logic          rs1_fwd_vld_o, rs2_fwd_vld_o;
  logic [31:0]   rs1_fwd_data_o, rs2_fwd_data_o;
`endif

  yarp_wb_arbiter #(.NUM_REQ(2), .XLEN(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_rd_addr_i (req_rd_addr_i),
    .req_data_i    (req_data_i),
    .rf_wr_en_o    (rf_wr_en_o),
    .rf_rd_addr_o  (rf_rd_addr_o),
    .rf_wr_data_o  (rf_wr_data_o),
`ifdef YARP_WB_FWD_EN
    .rs1_addr_i    (rs1_addr_i),
    .rs2_addr_i    (rs2_addr_i),
    .rs1_fwd_vld_o (rs1_fwd_vld_o),
    .rs2_fwd_vld_o (rs2_fwd_vld_o),
    .rs1_fwd_data_o(rs1_fwd_data_o),
    .rs2_fwd_data_o(rs2_fwd_data_o),
`endif
    .grant_o       (grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        rst;
    logic [1:0]  vld;
    logic [4:0]  rd0;
    logic [31:0] d0;
    logic [4:0]  rd1;
    logic [31:0] d1;
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  gnt;
    logic [1:0]  rdy;
  } vec_t;

  vec_t vecs [18];

  // Reference model state: per-requester slot contents and round-robin pointer.
  bit          mv   [N];
  logic [4:0]  mrd  [N];
  logic [31:0] mdat [N];
  int          mptr;

  function automatic vec_t mk(logic rst, logic [1:0] vld, logic [4:0] rd0, logic [31:0] d0,
                              logic [4:0] rd1, logic [31:0] d1, logic en, logic [4:0] rd,
                              logic [31:0] data, logic [1:0] gnt, logic [1:0] rdy);
    vec_t v;
    v.rst = rst; v.vld = vld; v.rd0 = rd0; v.d0 = d0; v.rd1 = rd1; v.d1 = d1;
    v.en = en; v.rd = rd; v.data = data; v.gnt = gnt; v.rdy = rdy;
    return v;
  endfunction

  function automatic logic [41:0] outs();
    return {rf_wr_en_o, rf_rd_addr_o, rf_wr_data_o, grant_o, req_ready_o};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [1:0] vld, input logic [4:0] rd0,
                       input logic [31:0] d0, input logic [4:0] rd1, input logic [31:0] d1);
    reset         = rst;
    req_valid_i   = vld;
    req_rd_addr_i = {rd1, rd0};
    req_data_i    = {d1, d0};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    tick();
  endtask

  initial begin
    int g0, g1;
    drive(1'b1, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
`ifdef YARP_WB_FWD_EN
    rs1_addr_i = 5'd0;
    rs2_addr_i = 5'd0;
`endif
    tick();

    //                rst vld   rd0    d0             rd1    d1            en  rd     data           gnt    rdy
    vecs[0]  = mk(1, 2'b11, 5'd5,  32'hAAAA,     5'd6,  32'hBBBB,     0, 5'd0,  32'h0,         2'b00, 2'b11);
    vecs[1]  = mk(1, 2'b11, 5'd5,  32'hAAAA,     5'd6,  32'hBBBB,     0, 5'd0,  32'h0,         2'b00, 2'b11);
    vecs[2]  = mk(0, 2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,        0, 5'd0,  32'h0,         2'b00, 2'b11);
    vecs[3]  = mk(0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1, 5'd5,  32'hDEADBEEF,  2'b01, 2'b11);
    vecs[4]  = mk(1, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        0, 5'd0,  32'h0,         2'b00, 2'b11);
    vecs[5]  = mk(0, 2'b11, 5'd1,  32'h11,       5'd2,  32'h22,       0, 5'd0,  32'h0,         2'b00, 2'b11);
    vecs[6]  = mk(0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1, 5'd1,  32'h11,        2'b01, 2'b01);
    vecs[7]  = mk(0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1, 5'd2,  32'h22,        2'b10, 2'b11);
    vecs[8]  = mk(0, 2'b10, 5'd0,  32'h0,        5'd0,  32'hFFFFFFFF, 0, 5'd0,  32'h0,         2'b00, 2'b11);
    vecs[9]  = mk(0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        0, 5'd0,  32'h0,         2'b00, 2'b11);
    vecs[10] = mk(0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        0, 5'd0,  32'h0,         2'b00, 2'b11);
    vecs[11] = mk(0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        0, 5'd0,  32'h0,         2'b00, 2'b11);
    vecs[12] = mk(0, 2'b01, 5'd9,  32'h99,       5'd0,  32'h0,        0, 5'd0,  32'h0,         2'b00, 2'b11);
    vecs[13] = mk(1, 2'b11, 5'd7,  32'h77,       5'd8,  32'h88,       1, 5'd9,  32'h99,        2'b01, 2'b11);
    vecs[14] = mk(0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        0, 5'd0,  32'h0,         2'b00, 2'b11);
    vecs[15] = mk(0, 2'b11, 5'd12, 32'hC,        5'd13, 32'hD,        0, 5'd0,  32'h0,         2'b00, 2'b11);
    vecs[16] = mk(0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1, 5'd12, 32'hC,         2'b01, 2'b01);
    vecs[17] = mk(0, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,        1, 5'd13, 32'hD,         2'b10, 2'b11);

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].rst, vecs[i].vld, vecs[i].rd0, vecs[i].d0, vecs[i].rd1, vecs[i].d1);
      #2;
      check($sformatf("vec%0d", i), 64'(outs()),
            64'({vecs[i].en, vecs[i].rd, vecs[i].data, vecs[i].gnt, vecs[i].rdy}));
      tick();
    end

    // Streaming from requester 0 alone: ready every cycle, one write per cycle.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      drive(1'b0, (k < 8) ? 2'b01 : 2'b00, 5'(3 + k), 32'h1000 + 32'(k), 5'd0, 32'd0);
      #2;
      check($sformatf("stream_ready%0d", k), 64'(req_ready_o[0]), 64'd1);
      if (k == 0)
        check("stream_idle", 64'(rf_wr_en_o), 64'd0);
      else
        check($sformatf("stream_wr%0d", k), 64'({rf_wr_en_o, rf_rd_addr_o, rf_wr_data_o}),
              64'({1'b1, 5'(2 + k), 32'h1000 + 32'(k - 1)}));
      tick();
    end

    // Fairness under full contention.
    do_reset();
    g0 = 0;
    g1 = 0;
    for (int c = 0; c < 11; c++) begin
      drive(1'b0, 2'b11, 5'd20, 32'hA0 + 32'(c), 5'd21, 32'hB0 + 32'(c));
      #2;
      if (c >= 1) begin
        check($sformatf("fair_gnt%0d", c), 64'(grant_o), (c % 2 == 1) ? 64'b01 : 64'b10);
        g0 += int'(grant_o[0]);
        g1 += int'(grant_o[1]);
      end
      tick();
    end
    check("fair_cnt0", 64'(g0), 64'd5);
    check("fair_cnt1", 64'(g1), 64'd5);

`ifdef YARP_WB_FWD_EN
    do_reset();
    drive(1'b0, 2'b01, 5'd7, 32'h7777, 5'd0, 32'd0);
    tick();
    drive(1'b0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    rs1_addr_i = 5'd7;
    rs2_addr_i = 5'd8;
    #2;
    check("fwd_rs1", 64'({rs1_fwd_vld_o, rs1_fwd_data_o}), 64'({1'b1, 32'h7777}));
    check("fwd_rs2", 64'({rs2_fwd_vld_o, rs2_fwd_data_o}), 64'({1'b0, 32'h0}));
    tick();
`endif

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < N; i++) mv[i] = 1'b0;
    mptr = 0;
    for (int c = 0; c < 1500; c++) begin
      logic        r;
      logic [1:0]  v;
      logic [4:0]  a [N];
      logic [31:0] d [N];
      logic [1:0]  er;
      logic [41:0] exp;
      int          g;
      r = ($urandom_range(0, 49) == 0);
      v = 2'($urandom);
      for (int i = 0; i < N; i++) begin
        a[i] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        d[i] = $urandom;
      end
      drive(r, v, a[0], d[0], a[1], d[1]);
      #2;
      g = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (mptr + k) % N;
        if (g < 0 && mv[j]) g = j;
      end
      for (int i = 0; i < N; i++) er[i] = !mv[i] || (g == i);
      if (g >= 0) exp = {1'b1, mrd[g], mdat[g], 2'(1 << g), er};
      else        exp = {1'b0, 5'd0, 32'd0, 2'b00, er};
      check($sformatf("rand%0d", c), 64'(outs()), 64'(exp));
      if (r) begin
        for (int i = 0; i < N; i++) mv[i] = 1'b0;
        mptr = 0;
      end else begin
        if (g >= 0) begin
          mv[g] = 1'b0;
          mptr  = (g + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
          if (v[i] && er[i] && a[i] != 5'd0) begin
            mv[i]   = 1'b1;
            mrd[i]  = a[i];
            mdat[i] = d[i];
          end
        end
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
